// File: rtl/iir_mac_scheduler.sv
// Purpose: NUM_CH independent biquad (2nd-order IIR) filters time-sharing one multiplier.
// Latency: done[c] 7 edges after req[c] is sampled when idle; each job occupies an 8-cycle slot.
// Backpressure: requests merge into a per-channel pending bit (overrun flags a merge); cfg_ready
//               drops only for writes aimed at the channel currently being computed.
// Ports: clk/reset (async active-high); req/in per-channel sample requests and packed samples;
//        cfg_we/cfg_ch/cfg_idx/cfg_data/cfg_ready coefficient write port; ovr_clr clears overrun;
//        out packed filter outputs; done per-channel update pulse; overrun sticky flags; busy.
module iir_mac_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int COEFF_WIDTH = 18,
    parameter int COEFF_SCALE = 14,
    parameter int DATA_WIDTH  = 16,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in,
    input  logic                           cfg_we,
    input  logic [CHW-1:0]                 cfg_ch,
    input  logic [2:0]                     cfg_idx,
    input  logic [COEFF_WIDTH-1:0]         cfg_data,
    output logic                           cfg_ready,
    input  logic                           ovr_clr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out,
    output logic [NUM_CH-1:0]              done,
    output logic [NUM_CH-1:0]              overrun,
    output logic                           busy
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = COEFF_WIDTH;
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic signed [CW-1:0] COEF_ONE = {{(CW-1){1'b0}}, 1'b1} << COEFF_SCALE;
    localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]                  state_q, state_d;
    logic [2:0]                  tap_q, tap_d;
    logic [CHW-1:0]              cur_q, cur_d;
    logic [CHW-1:0]              ptr_q, ptr_d;
    logic signed [DW-1:0]        x_q, x_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [NUM_CH-1:0]           pending_q, pending_d;
    logic [NUM_CH-1:0]           overrun_q, overrun_d;
    logic [NUM_CH-1:0]           done_q, done_d;
    logic signed [DW-1:0]        x1_q [NUM_CH], x1_d [NUM_CH];
    logic signed [DW-1:0]        x2_q [NUM_CH], x2_d [NUM_CH];
    logic signed [DW-1:0]        y1_q [NUM_CH], y1_d [NUM_CH];
    logic signed [DW-1:0]        y2_q [NUM_CH], y2_d [NUM_CH];
    logic signed [DW-1:0]        out_q [NUM_CH], out_d [NUM_CH];
    // Coefficient order per channel: B1, B2, B3, A2, A3.
    logic signed [CW-1:0]        coef_q [NUM_CH][5], coef_d [NUM_CH][5];

    logic                        gnt_vld, can_grant, tap_neg;
    logic [CHW-1:0]              gnt_ch, idx;
    logic [NUM_CH-1:0]           clr_mask;
    logic signed [DW-1:0]        samp, res;
    logic signed [CW-1:0]        coef;
    logic signed [PW-1:0]        prod;
    logic signed [AW-1:0]        prod_ext, shifted;

    assign busy      = (state_q != S_IDLE);
    assign cfg_ready = !(busy && (cfg_ch == cur_q));
    assign done      = done_q;
    assign overrun   = overrun_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out[g*DW +: DW] = out_q[g];
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        x_d       = x_q;
        acc_d     = acc_q;
        done_d    = '0;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        out_d     = out_q;
        coef_d    = coef_q;
        clr_mask  = '0;

        // Round-robin search starting at ptr_q (channel after the last grant).
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CHW'((int'(ptr_q) + i) % NUM_CH);
            if (!gnt_vld && pending_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
        // The cycle carrying a done pulse is a mandatory idle gap, which gives
        // every job a fixed 8-cycle slot when requests are back to back.
        can_grant = (state_q == S_IDLE) && gnt_vld && (done_q == '0);

        // Shared multiplier operand select, one tap per MAC cycle.
        samp    = '0;
        coef    = '0;
        tap_neg = 1'b0;
        case (tap_q)
            3'd0: begin samp = x_q;         coef = coef_q[cur_q][0]; end
            3'd1: begin samp = x1_q[cur_q]; coef = coef_q[cur_q][1]; end
            3'd2: begin samp = x2_q[cur_q]; coef = coef_q[cur_q][2]; end
            3'd3: begin samp = y1_q[cur_q]; coef = coef_q[cur_q][3]; tap_neg = 1'b1; end
            3'd4: begin samp = y2_q[cur_q]; coef = coef_q[cur_q][4]; tap_neg = 1'b1; end
            default: ;
        endcase
        prod     = samp * coef;
        prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

        // Floor scaling then saturation to the sample range.
        shifted = acc_q >>> COEFF_SCALE;
        if (shifted > SAT_MAX)      res = SAT_MAX[DW-1:0];
        else if (shifted < SAT_MIN) res = SAT_MIN[DW-1:0];
        else                        res = shifted[DW-1:0];

        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    cur_d            = gnt_ch;
                    ptr_d            = CHW'((int'(gnt_ch) + 1) % NUM_CH);
                    x_d              = in[gnt_ch*DW +: DW];
                    acc_d            = '0;
                    tap_d            = '0;
                    clr_mask[gnt_ch] = 1'b1;
                    state_d          = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = tap_neg ? (acc_q - prod_ext) : (acc_q + prod_ext);
                tap_d = tap_q + 3'd1;
                if (tap_q == 3'd4) state_d = S_WRITE;
            end
            S_WRITE: begin
                out_d[cur_q]  = res;
                y2_d[cur_q]   = y1_q[cur_q];
                y1_d[cur_q]   = res;
                x2_d[cur_q]   = x1_q[cur_q];
                x1_d[cur_q]   = x_q;
                done_d[cur_q] = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A request on the grant edge re-arms pending without counting as overrun.
        pending_d = (pending_q & ~clr_mask) | req;
        overrun_d = (ovr_clr ? '0 : overrun_q) | (req & pending_q & ~clr_mask);

        if (cfg_we && cfg_ready && (cfg_idx < 3'd5))
            coef_d[cfg_ch][cfg_idx] = cfg_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tap_q     <= '0;
            cur_q     <= '0;
            ptr_q     <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            done_q    <= '0;
            x1_q      <= '{default: '0};
            x2_q      <= '{default: '0};
            y1_q      <= '{default: '0};
            y2_q      <= '{default: '0};
            out_q     <= '{default: '0};
            for (int c = 0; c < NUM_CH; c++) begin
                coef_q[c][0] <= COEF_ONE;
                for (int k = 1; k < 5; k++) coef_q[c][k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            out_q     <= out_d;
            coef_q    <= coef_d;
        end
    end
endmodule

// File: tb/tb_iir_mac_scheduler.sv
module tb_iir_mac_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] in_bus;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [2:0]  cfg_idx;
    logic [17:0] cfg_data;
    logic        cfg_ready;
    logic        ovr_clr;
    logic [63:0] out_bus;
    logic [3:0]  done;
    logic [3:0]  overrun;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    iir_mac_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .in(in_bus),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .ovr_clr(ovr_clr), .out(out_bus), .done(done),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] outv(input int c);
        return out_bus[c*16 +: 16];
    endfunction

    task automatic set_in(input int c, input logic signed [15:0] v);
        in_bus[c*16 +: 16] = v;
    endtask

    task automatic pulse_req(input logic [3:0] m);
        req = m;
        step();
        req = 4'b0;
    endtask

    // Edges until done[ch] is seen, -1 if it never comes within the budget.
    task automatic wait_done(input int ch, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (done[ch] !== 1'b1 && cnt < 40);
        if (done[ch] !== 1'b1) cnt = -1;
    endtask

    task automatic count_done(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done[ch] === 1'b1) cnt++;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [2:0] i, input logic [17:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_idx = i; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; in_bus = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_idx = '0; cfg_data = '0; ovr_clr = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_out", out_bus, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        reset = 1'b0;
        step();

        // Pass-through after reset, idle latency of 7 edges.
        set_in(0, 16'sd1234);
        pulse_req(4'b0001);
        chk("busy_after_grant_edge", busy, 0);
        wait_done(0, n);
        chk("lat_ch0", n, 7);
        chk("pass_out0", outv(0), 1234);
        chk("pass_other_outs", out_bus[63:16], 0);
        step();
        chk("done_one_cycle", done, 0);

        // Ch1 three-tap moving sum at 0.25 each.
        cfg_write(2'd1, 3'd0, 18'd4096);
        cfg_write(2'd1, 3'd1, 18'd4096);
        cfg_write(2'd1, 3'd2, 18'd4096);
        cfg_write(2'd1, 3'd5, 18'd999);
        set_in(1, 16'sd1000);
        pulse_req(4'b0010); wait_done(1, n);
        chk("fir_lat1", n, 7);
        chk("fir_out1_a", outv(1), 250);
        pulse_req(4'b0010); wait_done(1, n);
        chk("fir_out1_b", outv(1), 500);
        pulse_req(4'b0010); wait_done(1, n);
        chk("fir_out1_c", outv(1), 750);
        chk("ch0_untouched", outv(0), 1234);

        // Ch2 gain of 4 saturates both ways.
        cfg_write(2'd2, 3'd0, 18'd65536);
        set_in(2, 16'sd16000);
        pulse_req(4'b0100); wait_done(2, n);
        chk("sat_pos", outv(2), 32767);
        set_in(2, -16'sd16000);
        pulse_req(4'b0100); wait_done(2, n);
        chk("sat_neg", outv(2), -32768);

        // Round robin: after ch1, ch2 beats ch0, jobs 8 cycles apart.
        pulse_req(4'b0010); wait_done(1, n);
        chk("rr_ch1_out", outv(1), 750);
        set_in(0, 16'sd100);
        set_in(2, 16'sd200);
        pulse_req(4'b0101);
        wait_done(2, n);
        chk("rr_ch2_first", n, 7);
        chk("rr_ch0_not_yet", done[0], 0);
        wait_done(0, n);
        chk("rr_ch0_spacing", n, 8);
        chk("rr_out2", outv(2), 800);
        chk("rr_out0", outv(0), 100);

        // Overrun on ch3 while ch0 is in service; single merged job.
        set_in(3, -16'sd77);
        pulse_req(4'b0001);
        req = 4'b1000; step(); step(); req = 4'b0;
        chk("overrun_set", overrun, 4'b1000);
        count_done(3, 30, n);
        chk("overrun_single_done", n, 1);
        chk("overrun_out3", outv(3), -77);
        chk("overrun_sticky", overrun, 4'b1000);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Coefficient write to the channel in service waits for IDLE.
        set_in(0, 16'sd500);
        pulse_req(4'b0001);
        step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_idx = 3'd0; cfg_data = 18'd4096;
        #1;
        chk("cfg_ready_other_ch", cfg_ready, 1);
        cfg_ch = 2'd0; cfg_data = 18'd8192;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            chk("cfg_blocked", cfg_ready, 0);
            step();
            n++;
        end
        chk("cfg_block_len", n, 6);
        chk("cfg_ready_idle", cfg_ready, 1);
        chk("cfg_job_old_coef", outv(0), 500);
        step();
        cfg_we = 1'b0;
        set_in(0, 16'sd1000);
        pulse_req(4'b0001); wait_done(0, n);
        chk("cfg_new_coef", outv(0), 500);
        chk("cfg_ch1_unchanged", outv(1), 750);

        // Reset mid-MAC: no done, outputs cleared, coefficients restored.
        pulse_req(4'b0001);
        step(); step();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out", out_bus, 0);
        chk("mid_rst_done", done, 0);
        step();
        reset = 1'b0;
        count_done(0, 12, n);
        chk("mid_rst_no_done", n, 0);
        chk("mid_rst_out0", outv(0), 0);
        set_in(0, 16'sd1234);
        pulse_req(4'b0001); wait_done(0, n);
        chk("post_rst_lat", n, 7);
        chk("post_rst_b1", outv(0), 1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/iir_mac_scheduler.md
IIR_MAC_SCHEDULER -- requirements
Module: iir_mac_scheduler

Interface
REQ-001 Parameter NUM_CH, 4, number of independent 2nd-order filter channels sharing one multiplier.
REQ-002 Parameter COEFF_WIDTH, 18, signed coefficient width.
REQ-003 Parameter COEFF_SCALE, 14, coefficient fraction bits; 1.0 = 2^COEFF_SCALE.
REQ-004 Parameter DATA_WIDTH, 16, signed sample width.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  NUM_CH  per-channel sample request; a 1 on channel c at an edge requests one filter update.
REQ-008 in  in  NUM_CH*DATA_WIDTH  signed samples; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 cfg_we  in  1  coefficient write strobe.
REQ-010 cfg_ch  in  2  target channel (clog2(NUM_CH) bits).
REQ-011 cfg_idx  in  3  coefficient select: 0=B1, 1=B2, 2=B3, 3=A2, 4=A3; 5-7 ignored.
REQ-012 cfg_data  in  COEFF_WIDTH  signed coefficient value.
REQ-013 cfg_ready  out  1  write accepted when cfg_we & cfg_ready at an edge.
REQ-014 ovr_clr  in  1  clears all overrun flags.
REQ-015 out  out  NUM_CH*DATA_WIDTH  latest filtered output per channel, same packing as in.
REQ-016 done  out  NUM_CH  one-cycle pulse when channel c output updates.
REQ-017 overrun  out  NUM_CH  sticky flag: request arrived while already pending.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 Per channel: difference equation y = B1*x + B2*x1 + B3*x2 - A2*y1 - A3*y2; x1,x2,y1,y2 held per channel.
REQ-020 pending[c] sets at any edge where req[c]=1; if pending[c] already 1 and not cleared that edge, overrun[c] sets; requests merge (one update).
REQ-021 FSM states IDLE, MAC, WRITE: IDLE->MAC when any pending; MAC->WRITE after 5 taps; WRITE->IDLE always.
REQ-022 Grant (IDLE edge): round-robin, search starts at channel after last granted; after reset channel 0 highest.
REQ-023 Grant edge captures in[c] as x, clears pending[c], zeroes accumulator; if req[c]=1 same edge, pending[c] stays 1, no overrun.
REQ-024 MAC: one multiply-accumulate per cycle, tap order B1*x, B2*x1, B3*x2, -A2*y1, -A3*y2; single multiplier instance.
REQ-025 Accumulator width DATA_WIDTH+COEFF_WIDTH+3, signed, no overflow possible.
REQ-026 Result = accumulator arithmetically shifted right COEFF_SCALE (floor), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-027 WRITE edge: out[c]<=result, y2<=y1, y1<=result, x2<=x1, x1<=x, done[c]<=1 for exactly one cycle.
REQ-028 Latency: done[c] high in the cycle after the 7th edge following the edge sampling req[c] (idle, no competitor); 8 cycles per job throughput.
REQ-029 cfg_ready = 0 only while busy and cfg_ch equals the channel in service; otherwise 1.
REQ-030 Accepted write updates the coefficient at that edge; cfg_idx 5-7 accepted and discarded.
REQ-031 ovr_clr clears all overrun flags; overrun set on same edge wins.
REQ-032 Channels' state and coefficients fully independent; writes never alter history.

Reset
REQ-033 Reset asserted (any time, including mid-MAC) immediately forces: state IDLE, pending 0, overrun 0, done 0, busy 0, out 0, all histories 0, round-robin pointer to channel 0.
REQ-034 Reset coefficients: B1 = 2^COEFF_SCALE, B2=B3=A2=A3=0 (pass-through); cfg_ready 1.

Verification
REQ-035 After reset, req[0] with in0=1234 -> done[0] 7 edges later, out0=1234, other outs 0.
REQ-036 Ch1 B1=B2=B3=4096, A=0; three requests with in1=1000 -> out1 = 250, 500, 750.
REQ-037 Ch2 B1=65536; in2=16000 -> out2=32767; in2=-16000 -> out2=-32768.
REQ-038 Serve ch1 alone, then req[0] and req[2] same edge -> done[2] before done[0], 8 cycles apart.
REQ-039 req[3] on two edges before its grant -> overrun[3]=1, single done[3]; ovr_clr -> overrun[3]=0.
REQ-040 Write to ch0 during ch0 job -> cfg_ready=0 until IDLE; reset pulse mid-MAC -> no done, out 0, B1 back to 16384.
